// File: rtl/adder.sv
// Registered 1-bit adder: captures a and b on each rising edge and presents
// {valid, carry, sum} from a single 3-bit output register.
module adder (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  output logic [2:0] c
);

  logic [2:0] c_d;
  logic [2:0] c_q;

  // Next result: reset wins over operand capture; otherwise sum/carry with valid set.
  // Bitwise xor/and keep X on a or b confined to the sum/carry bits.
  always_comb begin
    c_d = 3'b000;
    if (!rst) begin
      c_d[0] = a ^ b;
      c_d[1] = a & b;
      c_d[2] = 1'b1;
    end
  end

  // Output register; the only state in the block.
  always_ff @(posedge clk) begin
    c_q <= c_d;
  end

  // Drive c straight from the flops, with no combinational path from a or b.
  assign c = c_q;

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed plan plus random traffic, scoreboard
// queue filled by the driver and drained by an independent monitor.
module tb_adder;

  logic       clk;
  logic       rst;
  logic       a;
  logic       b;
  logic [2:0] c;

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_q[$];
  logic [2:0] last_exp;
  bit         have_last = 0;
  bit         done = 0;

  adder dut (
    .clk(clk),
    .rst(rst),
    .a  (a),
    .b  (b),
    .c  (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: reset clears everything, otherwise valid plus the arithmetic sum.
  function automatic logic [2:0] model(input logic r, input logic ai, input logic bi);
    int sum;
    if (r) return 3'b000;
    sum = int'(ai) + int'(bi);
    return {1'b1, 2'(sum)};
  endfunction

  // Inputs change on the falling edge; expectation queued for the next rising edge.
  task automatic step(input logic r, input logic ai, input logic bi);
    @(negedge clk);
    rst = r;
    a   = ai;
    b   = bi;
    exp_q.push_back(model(r, ai, bi));
    @(posedge clk);
  endtask

  // Monitor: after every rising edge, compare c against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      checks++;
      if (c !== e) begin
        errors++;
        $display("FAIL edge_result t=%0t got=%b expected=%b", $time, c, e);
      end
      last_exp  = e;
      have_last = 1'b1;
    end
  end

  // Hold check: operand changes at the falling edge must not disturb c.
  always @(negedge clk) begin
    #2;
    if (have_last && !done) begin
      checks++;
      if (c !== last_exp) begin
        errors++;
        $display("FAIL mid_cycle_hold t=%0t got=%b expected=%b", $time, c, last_exp);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a   = 1'b1;
    b   = 1'b1;

    // Reset for two edges with both operands high.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);

    // Truth-table sweep.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] v;
      v = 2'(i);
      step(1'b0, v[1], v[0]);
    end

    // Hold (1,1) for five edges.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);

    // Reset mid-stream, then resume with (0,1).
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Back-to-back toggling.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1'b0, 1'b1, 1'b1);
      else            step(1'b0, 1'b0, 1'b0);
    end

    // Random traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom));
    end

    // Let the monitor drain the queue.
    repeat (2) @(posedge clk);
    #3;
    done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
